// File: rtl/neuron_scheduler_pkg.sv
// Shared constants for the neuron scheduler: phase codes, FSM encoding and the
// default neuron-slot width.
package neuron_sched_pkg;

  localparam int NN_DEF = 8;

  localparam logic [1:0] PH_COUNT = 2'd0;
  localparam logic [1:0] PH_READ  = 2'd1;
  localparam logic [1:0] PH_CALC  = 2'd2;
  localparam logic [1:0] PH_WRITE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/neuron_scheduler_if.sv
// Control/status bundle between the scheduler and its client (neuron, synapse
// and spike-counter logic). master drives the controls, slave is the scheduler.
interface neuron_scheduler_if
  import neuron_sched_pkg::*;
#(
  parameter int NN = NN_DEF
);
  logic [31:0] half_cnt;
  logic        run;
  logic [NN:0] last_idx;
  logic [15:0] frames_per_sim;

  logic [NN:0] neuron_index;
  logic [1:0]  phase;
  logic        step_en;
  logic        read_en;
  logic        write_en;
  logic        data_valid;
  logic        frame_end;
  logic        sim_tick;
  logic        busy;

  modport master (
    output half_cnt, run, last_idx, frames_per_sim,
    input  neuron_index, phase, step_en, read_en, write_en,
           data_valid, frame_end, sim_tick, busy
  );

  modport slave (
    input  half_cnt, run, last_idx, frames_per_sim,
    output neuron_index, phase, step_en, read_en, write_en,
           data_valid, frame_end, sim_tick, busy
  );
endinterface

// File: rtl/neuron_scheduler_step_divider.sv
// Phase-step divider: one step pulse every half_cnt+1 cycles while not cleared.
module step_divider
  import neuron_sched_pkg::*;
(
  input  logic        clk,
  input  logic        reset_sim,
  input  logic        clr_i,
  input  logic [31:0] half_cnt_i,
  output logic        step_o
);

  logic [31:0] div_q, div_d;

  // >= rather than == so a shrinking half_cnt fires at once instead of wrapping
  assign step_o = !clr_i && (div_q >= half_cnt_i);

  // count up, restart on step or while held clear
  always_comb begin
    div_d = div_q + 32'd1;
    if (clr_i || step_o) div_d = '0;
  end

  // divider register
  always_ff @(posedge clk) begin
    if (reset_sim) div_q <= '0;
    else           div_q <= div_d;
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Time-multiplexed sequencer: walks neuron slots 0..last_idx through the
// COUNT/READ/CALC/WRITE phases, emitting single-clock enables and frame pulses.
module neuron_scheduler
  import neuron_sched_pkg::*;
#(
  parameter int NN = NN_DEF
)(
  input logic              clk,
  input logic              reset_sim,
  neuron_scheduler_if.slave sif
);

  localparam int IW = NN + 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, last_q, last_d;
  logic [1:0]      ph_q, ph_d;
  logic [15:0]     fcnt_q, fcnt_d;
  logic            dv_q, dv_d;
  logic            busy_q, rd_q, wr_q;
  logic            active, div_step, step, fend, tick;

  assign active = (state_q != ST_IDLE);

  step_divider u_div (
    .clk        (clk),
    .reset_sim  (reset_sim),
    .clr_i      (!active),
    .half_cnt_i (sif.half_cnt),
    .step_o     (div_step)
  );

  assign step = active && div_step;
  assign fend = step && (ph_q == PH_WRITE) && (idx_q == last_q);
  // a counter already past a lowered target still counts as a match
  assign tick = fend && (fcnt_q >= sif.frames_per_sim);

  // next state: DRAIN finishes the current frame unless run comes back
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sif.run) state_d = ST_RUN;
      ST_RUN:   if (!sif.run) state_d = fend ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: if (sif.run) state_d = ST_RUN;
                else if (fend) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // slot/phase walk, last_idx latch, frame counter and frame-start flag
  always_comb begin
    idx_d  = idx_q;
    ph_d   = ph_q;
    last_d = last_q;
    fcnt_d = fcnt_q;
    if (!active) begin
      idx_d  = '0;
      ph_d   = PH_COUNT;
      fcnt_d = '0;
      if (sif.run) last_d = sif.last_idx;
    end else if (step) begin
      ph_d = ph_q + 2'd1;
      if (ph_q == PH_WRITE) idx_d = fend ? '0 : idx_q + IW'(1);
      if (fend) begin
        last_d = sif.last_idx;
        fcnt_d = tick ? 16'd0 : fcnt_q + 16'd1;
      end
    end
    dv_d = (!active && sif.run) || (fend && state_d == ST_RUN);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset_sim) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ph_q    <= PH_COUNT;
      last_q  <= '0;
      fcnt_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      dv_q    <= dv_d;
      busy_q  <= (state_d != ST_IDLE);
      rd_q    <= (state_d != ST_IDLE) && (ph_d == PH_READ);
      wr_q    <= (state_d != ST_IDLE) && (ph_d == PH_WRITE);
    end
  end

  assign sif.neuron_index = idx_q;
  assign sif.phase        = ph_q;
  assign sif.step_en      = step;
  assign sif.read_en      = rd_q;
  assign sif.write_en     = wr_q;
  assign sif.data_valid   = dv_q;
  assign sif.frame_end    = fend;
  assign sif.sim_tick     = tick;
  assign sif.busy         = busy_q;

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler: each scenario pushes the expected
// event stream (step/frame_end/sim_tick/data_valid with cycle, index, phase),
// a monitor records what the DUT emits, and the scenario compares the two.
module tb_neuron_scheduler;
  import neuron_sched_pkg::*;

  localparam int NN = 8;

  logic clk = 1'b0;
  logic reset_sim = 1'b1;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, c0 = 0;
  int   obs_q[$], exp_q[$];

  neuron_scheduler_if #(.NN(NN)) sif();
  neuron_scheduler #(.NN(NN)) dut (.clk(clk), .reset_sim(reset_sim), .sif(sif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // event code: cycle (relative to start), type 1=step 2=frame_end 3=sim_tick 4=data_valid
  function automatic int enc(int k, int ty, int idx, int ph);
    return k * 100000 + ty * 10000 + idx * 4 + ph;
  endfunction

  always @(negedge clk) begin
    if (sif.step_en)    obs_q.push_back(enc(cyc - c0, 1, int'(sif.neuron_index), int'(sif.phase)));
    if (sif.frame_end)  obs_q.push_back(enc(cyc - c0, 2, 0, 0));
    if (sif.sim_tick)   obs_q.push_back(enc(cyc - c0, 3, 0, 0));
    if (sif.data_valid) obs_q.push_back(enc(cyc - c0, 4, 0, 0));
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time expired before summary");
    $fatal(1, "timeout");
  end

  // advance to just after the edge that begins relative cycle k
  task automatic goto(input int k);
    while (cyc < c0 + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input int hc, input int li, input int fps);
    @(posedge clk);
    #1;
    c0 = cyc;
    obs_q.delete();
    exp_q.delete();
    sif.half_cnt       = hc;
    sif.last_idx       = li[NN:0];
    sif.frames_per_sim = fps[15:0];
    sif.run            = 1'b1;
  endtask

  // drop run and wait (bounded) for busy low; kid = -1 if it never falls
  task automatic wait_idle(output int kid);
    sif.run = 1'b0;
    kid = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!sif.busy) begin
        kid = cyc - c0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sif.half_cnt = 0; sif.run = 1'b1; sif.last_idx = '0; sif.frames_per_sim = '0;
    reset_sim = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({sif.busy, sif.neuron_index, sif.phase, sif.read_en, sif.write_en, sif.data_valid,
         sif.step_en, sif.frame_end, sif.sim_tick} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b idx=%0d ph=%0d dv=%b step=%b want all 0",
               sif.busy, sif.neuron_index, sif.phase, sif.data_valid, sif.step_en);
    end
    sif.run = 1'b0;
    @(posedge clk); #1;
    reset_sim = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int kid;
    start(0, 3, 0);
    for (int k = 1; k <= 48; k++) begin
      exp_q.push_back(enc(k, 1, ((k - 1) / 4) % 4, (k - 1) % 4));
      if (k % 16 == 0) begin
        exp_q.push_back(enc(k, 2, 0, 0));
        exp_q.push_back(enc(k, 3, 0, 0));
      end
      if (k % 16 == 1) exp_q.push_back(enc(k, 4, 0, 0));
    end
    goto(2); @(negedge clk);
    n_chk++;
    if ({sif.read_en, sif.write_en} !== 2'b10) begin
      n_fail++; $display("FAIL basic_read_en: got rd/wr=%b%b want 10", sif.read_en, sif.write_en);
    end
    goto(4); @(negedge clk);
    n_chk++;
    if ({sif.read_en, sif.write_en} !== 2'b01) begin
      n_fail++; $display("FAIL basic_write_en: got rd/wr=%b%b want 01", sif.read_en, sif.write_en);
    end
    goto(48);
    wait_idle(kid);
    n_chk++;
    if (kid != 49 || sif.neuron_index !== '0) begin
      n_fail++; $display("FAIL basic_stop: got idle at %0d idx=%0d want 49 idx=0", kid, sif.neuron_index);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL basic_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_divider();
    int kid;
    start(2, 1, 2);
    for (int k = 1; k <= 72; k++) begin
      if (k % 3 == 0) exp_q.push_back(enc(k, 1, ((k / 3 - 1) / 4) % 2, (k / 3 - 1) % 4));
      if (k % 24 == 0) exp_q.push_back(enc(k, 2, 0, 0));
      if (k == 72) exp_q.push_back(enc(k, 3, 0, 0));
      if (k % 24 == 1) exp_q.push_back(enc(k, 4, 0, 0));
    end
    goto(72);
    wait_idle(kid);
    n_chk++;
    if (kid != 73) begin
      n_fail++; $display("FAIL divider_stop: got idle at %0d want 73", kid);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL divider_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL divider_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_drain();
    int kid, lows;
    // run drops at slot 2 READ; the frame still completes through slot 5
    start(0, 5, 0);
    for (int k = 1; k <= 24; k++) exp_q.push_back(enc(k, 1, (k - 1) / 4, (k - 1) % 4));
    exp_q.push_back(enc(24, 2, 0, 0));
    exp_q.push_back(enc(24, 3, 0, 0));
    exp_q.insert(1, enc(1, 4, 0, 0));
    goto(10); @(negedge clk);
    n_chk++;
    if (sif.neuron_index !== 9'd2 || sif.phase !== PH_READ) begin
      n_fail++; $display("FAIL drain_position: got idx=%0d ph=%0d want 2/1", sif.neuron_index, sif.phase);
    end
    wait_idle(kid);
    n_chk++;
    if (kid != 25 || sif.neuron_index !== '0) begin
      n_fail++; $display("FAIL drain_stop: got idle at %0d idx=%0d want 25 idx=0", kid, sif.neuron_index);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL drain_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL drain_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
    // run re-raised during DRAIN: no idle gap, frames continue seamlessly
    start(0, 5, 0);
    lows = 0;
    for (int k = 1; k <= 48; k++) begin
      exp_q.push_back(enc(k, 1, ((k - 1) / 4) % 6, (k - 1) % 4));
      if (k % 24 == 0) begin
        exp_q.push_back(enc(k, 2, 0, 0));
        exp_q.push_back(enc(k, 3, 0, 0));
      end
      if (k % 24 == 1) exp_q.push_back(enc(k, 4, 0, 0));
    end
    for (int k = 1; k <= 48; k++) begin
      goto(k);
      if (k == 10) sif.run = 1'b0;
      if (k == 12) sif.run = 1'b1;
      if (k == 40) sif.run = 1'b0;
      @(negedge clk);
      if (!sif.busy) lows++;
    end
    n_chk++;
    if (lows != 0) begin
      n_fail++; $display("FAIL redrain_busy_gap: got %0d idle cycles want 0", lows);
    end
    wait_idle(kid);
    n_chk++;
    if (kid != 49) begin
      n_fail++; $display("FAIL redrain_stop: got idle at %0d want 49", kid);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL redrain_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL redrain_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_last_change();
    int kid;
    start(0, 3, 1);
    for (int k = 1; k <= 48; k++) begin
      exp_q.push_back(enc(k, 1, (k <= 16) ? (k - 1) / 4 : (k - 17) / 4, (k - 1) % 4));
      if (k == 16 || k == 48) exp_q.push_back(enc(k, 2, 0, 0));
      if (k == 48) exp_q.push_back(enc(k, 3, 0, 0));
      if (k == 1 || k == 17) exp_q.push_back(enc(k, 4, 0, 0));
    end
    goto(5);
    sif.last_idx = 9'd7;
    goto(48);
    wait_idle(kid);
    n_chk++;
    if (kid != 49) begin
      n_fail++; $display("FAIL last_change_stop: got idle at %0d want 49", kid);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL last_change_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL last_change_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int kid;
    start(0, 7, 0);
    for (int k = 1; k <= 19; k++) exp_q.push_back(enc(k, 1, (k - 1) / 4, (k - 1) % 4));
    exp_q.insert(1, enc(1, 4, 0, 0));
    for (int k = 21; k <= 52; k++) begin
      exp_q.push_back(enc(k, 1, (k - 21) / 4, (k - 21) % 4));
      if (k == 52) begin
        exp_q.push_back(enc(k, 2, 0, 0));
        exp_q.push_back(enc(k, 3, 0, 0));
      end
      if (k == 21) exp_q.push_back(enc(k, 4, 0, 0));
    end
    goto(19); @(negedge clk);
    n_chk++;
    if (sif.neuron_index !== 9'd4 || sif.phase !== PH_CALC) begin
      n_fail++; $display("FAIL rstmid_position: got idx=%0d ph=%0d want 4/2", sif.neuron_index, sif.phase);
    end
    reset_sim = 1'b1;
    goto(20);
    reset_sim = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({sif.busy, sif.neuron_index, sif.phase, sif.read_en, sif.write_en, sif.data_valid,
         sif.step_en, sif.frame_end, sif.sim_tick} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got busy=%b idx=%0d ph=%0d dv=%b step=%b want all 0",
               sif.busy, sif.neuron_index, sif.phase, sif.data_valid, sif.step_en);
    end
    goto(21); @(negedge clk);
    n_chk++;
    if (!(sif.busy === 1'b1 && sif.data_valid === 1'b1 && sif.neuron_index === '0 && sif.phase === PH_COUNT)) begin
      n_fail++; $display("FAIL rstmid_restart: got busy=%b dv=%b idx=%0d ph=%0d want 1 1 0 0",
                         sif.busy, sif.data_valid, sif.neuron_index, sif.phase);
    end
    wait_idle(kid);
    n_chk++;
    if (kid != 53) begin
      n_fail++; $display("FAIL rstmid_stop: got idle at %0d want 53", kid);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_shrink();
    int kid;
    // one-slot frame; half_cnt drops 10 -> 1 while the divider sits at 6
    start(10, 0, 0);
    exp_q.push_back(enc(1, 4, 0, 0));
    exp_q.push_back(enc(7, 1, 0, 0));
    exp_q.push_back(enc(9, 1, 0, 1));
    exp_q.push_back(enc(11, 1, 0, 2));
    exp_q.push_back(enc(13, 1, 0, 3));
    exp_q.push_back(enc(13, 2, 0, 0));
    exp_q.push_back(enc(13, 3, 0, 0));
    goto(7);
    sif.half_cnt = 1;
    wait_idle(kid);
    n_chk++;
    if (kid != 14 || sif.neuron_index !== '0) begin
      n_fail++; $display("FAIL shrink_stop: got idle at %0d idx=%0d want 14 idx=0", kid, sif.neuron_index);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL shrink_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (i >= obs_q.size() || obs_q[i] != exp_q[i]) begin
        n_fail++; $display("FAIL shrink_event %0d: got %0d want %0d", i, (i < obs_q.size()) ? obs_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_drain();
    test_last_change();
    test_reset_mid();
    test_shrink();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
